// File: rtl/muldiv_if.sv
// EX-stage <-> muldiv_unit bundle: op launch, MTHI/MTLO writes, status and HI/LO readback.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             dbz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs, rt, hi_we, lo_we, wdata,
    input  busy, done, dbz, hi, lo
  );

  modport slave (
    input  start, op, rs, rt, hi_we, lo_we, wdata,
    output busy, done, dbz, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS HI/LO multiply/divide built around one shared 32-bit adder.
// Define MULDIV_DIV_EN to include DIV/DIVU and the divide-by-zero flag.
module muldiv_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] HILO_RESET = '0
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [4:0]       cnt;
  logic             fix_ph;
  logic [WIDTH-1:0] acc_hi, acc_lo, mcand;
  logic             neg_lo, neg_hi, carry_sv;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             op_legal, accept, sign_op;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  logic [WIDTH-1:0] run_hi, run_lo;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_ci, add_co;

`ifdef MULDIV_DIV_EN
  logic is_div, div_zero, div_take, dbz_q;
  assign op_legal = 1'b1;
  assign div_zero = bus.op[1] && (bus.rt == '0);
`else
  assign op_legal = ~bus.op[1];
`endif

  assign accept  = (state == IDLE) && bus.start && op_legal;
  assign sign_op = ~bus.op[0];
  assign rs_abs  = (sign_op && bus.rs[WIDTH-1]) ? (~bus.rs + WIDTH'(1)) : bus.rs;
  assign rt_abs  = (sign_op && bus.rt[WIDTH-1]) ? (~bus.rt + WIDTH'(1)) : bus.rt;

  // The Add block: one operand pair plus carry-in per cycle; overflow is never needed.
  assign {add_co, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_ci};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    add_a  = acc_hi;
    add_b  = '0;
    add_ci = 1'b0;
    case (state)
      RUN: begin
        add_b = acc_lo[0] ? mcand : '0;
`ifdef MULDIV_DIV_EN
        if (is_div) begin
          add_a  = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
          add_b  = ~mcand;
          add_ci = 1'b1;
        end
`endif
      end
      FIX: begin
        add_a  = fix_ph ? ~acc_hi : ~acc_lo;
        add_ci = fix_ph ? carry_sv : 1'b1;
      end
      default: ;
    endcase
  end

  // Multiply: adding zero when the multiplier bit is clear yields {0,acc_hi}, so the
  // shifted 65-bit {CF,sum,acc_lo} covers both branches of the step.
  always_comb begin
    run_hi = {add_co, add_sum[WIDTH-1:1]};
    run_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_take = acc_hi[WIDTH-1] | add_co;
    if (is_div) begin
      run_hi = div_take ? add_sum : {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
      run_lo = {acc_lo[WIDTH-2:0], div_take};
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = RUN;
`ifdef MULDIV_DIV_EN
        if (accept && div_zero) state_nxt = DONE;
`endif
      end
      RUN:     if (cnt == '0) state_nxt = FIX;
      FIX:     if (fix_ph) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      fix_ph   <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      carry_sv <= 1'b0;
      hi_q     <= HILO_RESET;
      lo_q     <= HILO_RESET;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      dbz_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (accept) begin
            cnt    <= '1;
            fix_ph <= 1'b0;
            acc_hi <= '0;
            acc_lo <= rt_abs;
            mcand  <= rs_abs;
            neg_lo <= sign_op & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
            neg_hi <= sign_op & (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
`ifdef MULDIV_DIV_EN
            is_div <= bus.op[1];
            dbz_q  <= div_zero;
            if (bus.op[1]) begin
              // Dividend shifts out of acc_lo into the remainder; the remainder sign follows rs.
              acc_lo <= rs_abs;
              mcand  <= rt_abs;
              neg_hi <= sign_op & bus.rs[WIDTH-1];
            end
`endif
          end
        end
        RUN: begin
          cnt    <= cnt - 5'd1;
          acc_hi <= run_hi;
          acc_lo <= run_lo;
        end
        FIX: begin
          fix_ph <= 1'b1;
          if (!fix_ph) begin
            if (neg_lo) acc_lo <= add_sum;
`ifdef MULDIV_DIV_EN
            carry_sv <= is_div | add_co;
`else
            carry_sv <= add_co;
`endif
          end else begin
            hi_q <= neg_hi ? add_sum : acc_hi;
            lo_q <= acc_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
`ifdef MULDIV_DIV_EN
  assign bus.dbz  = dbz_q;
`else
  assign bus.dbz  = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [31:0] model_hi, model_lo;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: HI/LO result of one operation from MIPS arithmetic rules.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, b,
                                 input logic [31:0] cur_hi, cur_lo,
                                 output logic [31:0] r_hi, r_lo,
                                 output logic r_dbz, output int lat);
    logic [63:0] p;
    longint sa, sb;
    sa    = longint'($signed(a));
    sb    = longint'($signed(b));
    r_hi  = cur_hi;
    r_lo  = cur_lo;
    r_dbz = 1'b0;
    lat   = 35;
    case (op)
      2'd0: begin p = 64'(sa * sb); r_hi = p[63:32]; r_lo = p[31:0]; end
      2'd1: begin p = {32'b0, a} * {32'b0, b}; r_hi = p[63:32]; r_lo = p[31:0]; end
      default: begin
        if (b == 32'd0) begin
          r_dbz = 1'b1;
          lat   = 1;
        end else if (op == 2'd2) begin
          r_lo = 32'(sa / sb);
          r_hi = 32'(sa % sb);
        end else begin
          r_lo = a / b;
          r_hi = a % b;
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, b,
                        input logic whi, wlo, input logic [31:0] wd, input string tag);
    logic [31:0] e_hi, e_lo;
    logic        e_dbz;
    int          lat, cyc;
    bit          seen;
    if (whi) model_hi = wd;
    if (wlo) model_lo = wd;
    ref_op(op, a, b, model_hi, model_lo, e_hi, e_lo, e_dbz, lat);
    bus.op = op; bus.rs = a; bus.rt = b; bus.start = 1'b1;
    bus.hi_we = whi; bus.lo_we = wlo; bus.wdata = wd;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.rs = $urandom; bus.rt = $urandom; bus.wdata = $urandom;
    cyc = 1;
    if (lat > 1) begin
      check({tag, ":busy1"}, 64'(bus.busy), 64'd1);
      check({tag, ":hold_hi"}, 64'(bus.hi), 64'(model_hi));
      check({tag, ":hold_lo"}, 64'(bus.lo), 64'(model_lo));
    end
    seen = 0;
    while (!seen && cyc <= 60) begin
      if (bus.done) seen = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, ":done_seen"}, 64'(seen), 64'd1);
    check({tag, ":latency"}, 64'(cyc), 64'(lat));
    check({tag, ":busy_at_done"}, 64'(bus.busy), 64'd1);
    check({tag, ":hi"}, 64'(bus.hi), 64'(e_hi));
    check({tag, ":lo"}, 64'(bus.lo), 64'(e_lo));
    check({tag, ":dbz"}, 64'(bus.dbz), 64'(e_dbz));
    model_hi = e_hi;
    model_lo = e_lo;
    @(posedge clk); #1;
    check({tag, ":done_pulse"}, 64'(bus.done), 64'd0);
    check({tag, ":idle"}, 64'(bus.busy), 64'd0);
  endtask

  task automatic write_hilo(input logic whi, wlo, input logic [31:0] wd, input string tag);
    bus.hi_we = whi; bus.lo_we = wlo; bus.wdata = wd;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = $urandom;
    if (whi) model_hi = wd;
    if (wlo) model_lo = wd;
    check({tag, ":hi"}, 64'(bus.hi), 64'(model_hi));
    check({tag, ":lo"}, 64'(bus.lo), 64'(model_lo));
  endtask

`ifndef MULDIV_DIV_EN
  task automatic run_illegal(input logic [1:0] op, input string tag);
    bit any_busy, any_done;
    bus.op = op; bus.rs = $urandom; bus.rt = $urandom; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    any_busy = 0;
    any_done = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.busy) any_busy = 1;
      if (bus.done) any_done = 1;
      @(posedge clk); #1;
    end
    check({tag, ":no_busy"}, 64'(any_busy), 64'd0);
    check({tag, ":no_done"}, 64'(any_done), 64'd0);
    check({tag, ":hi"}, 64'(bus.hi), 64'(model_hi));
    check({tag, ":lo"}, 64'(bus.lo), 64'(model_lo));
    check({tag, ":dbz"}, 64'(bus.dbz), 64'd0);
  endtask
`endif

  initial begin
    int   ndone, dcyc;
    bit   seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.start = 1'b0; bus.op = 2'd0; bus.rs = '0; bus.rt = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    check("reset:busy", 64'(bus.busy), 64'd0);
    check("reset:done", 64'(bus.done), 64'd0);
    check("reset:dbz",  64'(bus.dbz),  64'd0);
    check("reset:hi",   64'(bus.hi),   64'd0);
    check("reset:lo",   64'(bus.lo),   64'd0);
    model_hi = '0;
    model_lo = '0;

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "multu_max");
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         1'b0, 1'b0, '0, "mult_neg3x7");
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, '0, "mult_minxmin");
    run_op(2'd0, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, '0, "mult_minx1");
    run_op(2'd1, 32'd3, 32'd5, 1'b1, 1'b1, 32'hA5A5_A5A5, "wr_with_start");
    write_hilo(1'b1, 1'b0, 32'h0BAD_F00D, "mthi");
    write_hilo(1'b0, 1'b1, 32'h1357_9BDF, "mtlo");

`ifdef MULDIV_DIV_EN
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0, '0, "div_neg7by2");
    run_op(2'd3, 32'd100, 32'd7,               1'b0, 1'b0, '0, "divu_100by7");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, '0, "div_min_by_m1");
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE,         1'b0, 1'b0, '0, "div_7by_neg2");
    write_hilo(1'b1, 1'b1, 32'h0000_1234, "preset_1234");
    run_op(2'd3, 32'd5, 32'd0,                 1'b0, 1'b0, '0, "divu_by_zero");
    run_op(2'd1, 32'd2, 32'd3,                 1'b0, 1'b0, '0, "dbz_cleared");
`else
    run_illegal(2'd2, "div_disabled");
    run_illegal(2'd3, "divu_disabled");
`endif

    for (int i = 0; i < 24; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
`ifdef MULDIV_DIV_EN
      rop = 2'($urandom_range(0, 3));
`else
      rop = 2'($urandom_range(0, 1));
`endif
      ra = pick();
      rb = pick();
      run_op(rop, ra, rb, 1'b0, 1'b0, '0, "rand");
    end

    // MULTU 6*7 with stray starts at cycles 5 and 20 and an MTHI/MTLO while busy.
    bus.op = 2'd1; bus.rs = 32'd6; bus.rt = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    for (int c = 1; c <= 50; c++) begin
      bus.start = (c == 5 || c == 20);
      bus.rs    = 32'd100;
      bus.rt    = 32'd100;
      bus.hi_we = (c == 10);
      bus.lo_we = (c == 10);
      bus.wdata = 32'hDEAD_BEEF;
      if (c == 12) begin
        check("busy_write:hi", 64'(bus.hi), 64'(model_hi));
        check("busy_write:lo", 64'(bus.lo), 64'(model_lo));
      end
      if (bus.done) begin
        ndone++;
        dcyc = c;
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("restart:done_count", 64'(ndone), 64'd1);
    check("restart:done_cycle", 64'(dcyc), 64'd35);
    check("restart:lo", 64'(bus.lo), 64'd42);
    check("restart:hi", 64'(bus.hi), 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd42;

    // Asynchronous reset in the middle of a MULT.
    bus.op = 2'd0; bus.rs = 32'hFFFF_FFFB; bus.rt = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("abort:busy_before", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort:busy", 64'(bus.busy), 64'd0);
    check("abort:done", 64'(bus.done), 64'd0);
    check("abort:hi",   64'(bus.hi),   64'd0);
    check("abort:lo",   64'(bus.lo),   64'd0);
    @(negedge clk) rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) seen = 1;
    end
    check("abort:quiet", 64'(seen), 64'd0);
    model_hi = '0;
    model_lo = '0;
    run_op(2'd0, 32'hFFFF_FFFB, 32'd9, 1'b0, 1'b0, '0, "after_abort");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
